// File: rtl/scad_pkg.sv
// ============================================================================
// Module      : scad_pkg
// Description : Shared encodings for the SCAD shift-count datapath.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package scad_pkg;

    localparam logic [2:0] C_OP_A     = 3'd0;
    localparam logic [2:0] C_OP_AMB1  = 3'd1;
    localparam logic [2:0] C_OP_APB   = 3'd2;
    localparam logic [2:0] C_OP_AM1   = 3'd3;
    localparam logic [2:0] C_OP_AP1   = 3'd4;
    localparam logic [2:0] C_OP_AMB   = 3'd5;
    localparam logic [2:0] C_OP_OR    = 3'd6;
    localparam logic [2:0] C_OP_AND   = 3'd7;

    localparam logic [1:0] C_SCADA_FE       = 2'd0;
    localparam logic [1:0] C_SCADA_AR_EXP   = 2'd1;
    localparam logic [1:0] C_SCADA_AR_SHIFT = 2'd2;
    localparam logic [1:0] C_SCADA_MAGIC    = 2'd3;

    localparam logic [1:0] C_SCADB_SC       = 2'd0;
    localparam logic [1:0] C_SCADB_AR_SHIFT = 2'd1;
    localparam logic [1:0] C_SCADB_FE       = 2'd2;
    localparam logic [1:0] C_SCADB_ZERO     = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/scad_alu.sv
// ============================================================================
// Module      : scad_alu
// Description : SCADA/SCADB source muxes and the W-bit SCAD function unit.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module scad_alu
    import scad_pkg::*;
#(
    parameter int W       = 10,
    parameter int AR_W    = 36,
    parameter int MAGIC_W = 9
) (
    input  logic [2:0]         scad_op,
    input  logic [1:0]         scada_sel,
    input  logic [1:0]         scadb_sel,
    input  logic [AR_W-1:0]    ar,
    input  logic [MAGIC_W-1:0] magic,
    input  logic [W-1:0]       fe,
    input  logic [W-1:0]       sc,
    output logic [W-1:0]       scad
);

    logic [W-1:0] w_a;
    logic [W-1:0] w_b;
    logic [W-1:0] w_ar_shift;
    logic         w_unused_ar;

    // AR bit 0 is the MSB, so AR[0:8] is the top nine bits of the vector.
    assign w_ar_shift  = {{(W-9){ar[AR_W-1]}}, ar[AR_W-1 -: 9]};
    assign w_unused_ar = ^ar[AR_W-10:6];

    always_comb begin
        w_a = '0;
        case (scada_sel)
            C_SCADA_FE:       w_a = fe;
            C_SCADA_AR_EXP:   w_a = {{(W-6){1'b0}}, ar[5:0]};
            C_SCADA_AR_SHIFT: w_a = w_ar_shift;
            C_SCADA_MAGIC:    w_a = {{(W-MAGIC_W){magic[MAGIC_W-1]}}, magic};
            default:          w_a = '0;
        endcase
    end

    always_comb begin
        w_b = '0;
        case (scadb_sel)
            C_SCADB_SC:       w_b = sc;
            C_SCADB_AR_SHIFT: w_b = w_ar_shift;
            C_SCADB_FE:       w_b = fe;
            C_SCADB_ZERO:     w_b = '0;
            default:          w_b = '0;
        endcase
    end

    always_comb begin
        scad = w_a;
        case (scad_op)
            C_OP_A:    scad = w_a;
            C_OP_AMB1: scad = w_a + ~w_b;
            C_OP_APB:  scad = w_a + w_b;
            C_OP_AM1:  scad = w_a - {{(W-1){1'b0}}, 1'b1};
            C_OP_AP1:  scad = w_a + {{(W-1){1'b0}}, 1'b1};
            C_OP_AMB:  scad = w_a - w_b;
            C_OP_OR:   scad = w_a | w_b;
            C_OP_AND:  scad = w_a & w_b;
            default:   scad = w_a;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/scad_seq.sv
// ============================================================================
// Module      : scad_seq
// Description : FE/SC registers and the shift-count loop sequencer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module scad_seq
    import scad_pkg::*;
#(
    parameter int W       = 10,
    parameter int AR_W    = 36,
    parameter int MAGIC_W = 9,
    parameter int THRESH  = 36
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2:0]         scad_op,
    input  logic [1:0]         scada_sel,
    input  logic [1:0]         scadb_sel,
    input  logic [AR_W-1:0]    ar,
    input  logic [MAGIC_W-1:0] magic,
    input  logic               fe_load,
    input  logic               sc_load,
    input  logic               start,
    input  logic               abort,
    output logic [W-1:0]       scad,
    output logic [W-1:0]       fe,
    output logic [W-1:0]       sc,
    output logic               scad_eq0,
    output logic               scad_sign,
    output logic               fe_sign,
    output logic               sc_sign,
    output logic               sc_ge_thresh,
    output logic               busy,
    output logic               step,
    output logic               done
);

    localparam logic signed [W-1:0] C_THRESH = THRESH[W-1:0];
    localparam logic [W-1:0]        C_ONE    = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] w_scad;
    logic [W-1:0] fe_q, fe_d;
    logic [W-1:0] sc_q, sc_d;
    state_e       state_q, state_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    scad_alu #(
        .W       (W),
        .AR_W    (AR_W),
        .MAGIC_W (MAGIC_W)
    ) u_alu (
        .scad_op   (scad_op),
        .scada_sel (scada_sel),
        .scadb_sel (scadb_sel),
        .ar        (ar),
        .magic     (magic),
        .fe        (fe_q),
        .sc        (sc_q),
        .scad      (w_scad)
    );

    always_comb begin
        fe_d    = fe_q;
        sc_d    = sc_q;
        state_d = state_q;
        if (fe_load) begin
            fe_d = w_scad;
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    sc_d = w_scad;
                    // A zero or negative count finishes without any steps.
                    if (w_scad == '0 || w_scad[W-1]) begin
                        state_d = DONE;
                    end else begin
                        state_d = COUNT;
                    end
                end else if (sc_load) begin
                    sc_d = w_scad;
                end
            end
            COUNT: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    sc_d = sc_q - C_ONE;
                    if (sc_q == C_ONE) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == COUNT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fe_q    <= '0;
            sc_q    <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            fe_q    <= fe_d;
            sc_q    <= sc_d;
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // An aborting cycle is a COUNT cycle that does not shift.
    assign step         = busy_q & ~abort;
    assign busy         = busy_q;
    assign done         = done_q;
    assign scad         = w_scad;
    assign fe           = fe_q;
    assign sc           = sc_q;
    assign scad_eq0     = (w_scad == '0);
    assign scad_sign    = w_scad[W-1];
    assign fe_sign      = fe_q[W-1];
    assign sc_sign      = sc_q[W-1];
    assign sc_ge_thresh = ($signed(sc_q) >= C_THRESH);

endmodule

`default_nettype wire

// File: tb/tb_scad_seq.sv
// ============================================================================
// Module      : tb_scad_seq
// Description : Scoreboard bench for scad_seq against a loop-level model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_scad_seq;

    localparam int MASK   = 1023;
    localparam int THRESH = 36;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  scad_op;
    logic [1:0]  scada_sel, scadb_sel;
    logic [35:0] ar;
    logic [8:0]  magic;
    logic        fe_load, sc_load, start, abort;
    logic [9:0]  scad, fe, sc;
    logic        scad_eq0, scad_sign, fe_sign, sc_sign, sc_ge_thresh;
    logic        busy, step, done;

    scad_seq dut (
        .clk(clk), .rst_n(rst_n), .scad_op(scad_op), .scada_sel(scada_sel),
        .scadb_sel(scadb_sel), .ar(ar), .magic(magic), .fe_load(fe_load),
        .sc_load(sc_load), .start(start), .abort(abort), .scad(scad), .fe(fe),
        .sc(sc), .scad_eq0(scad_eq0), .scad_sign(scad_sign), .fe_sign(fe_sign),
        .sc_sign(sc_sign), .sc_ge_thresh(sc_ge_thresh), .busy(busy),
        .step(step), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int scad;
        int fe;
        int sc;
        int flags;
        int ctl;
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];
    int   total = 0;
    int   bad = 0;
    int   steps_seen = 0;

    // Model: register values, steps still owed by a running loop, and a pending done.
    int m_fe = 0, m_sc = 0, m_left = 0, m_span = 0;
    bit m_done = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int to_s(input int v);
        return (v >= 512) ? v - 1024 : v;
    endfunction

    function automatic int ref_scad(input int op, input int asel, input int bsel,
                                    input logic [35:0] a_r, input int mg,
                                    input int rfe, input int rsc);
        int a, b, top9, r;
        top9 = int'(a_r[35:27]);
        if (top9 >= 256) top9 -= 512;
        case (asel)
            0:       a = rfe;
            1:       a = int'(a_r[5:0]);
            2:       a = top9;
            default: a = (mg >= 256) ? mg - 512 : mg;
        endcase
        case (bsel)
            0:       b = rsc;
            1:       b = top9;
            2:       b = rfe;
            default: b = 0;
        endcase
        case (op)
            0:       r = a;
            1:       r = a - b - 1;
            2:       r = a + b;
            3:       r = a - 1;
            4:       r = a + 1;
            5:       r = a - b;
            6:       r = (a & MASK) | (b & MASK);
            default: r = (a & MASK) & (b & MASK);
        endcase
        return r & MASK;
    endfunction

    function automatic int cur_scad();
        return ref_scad(int'(scad_op), int'(scada_sel), int'(scadb_sel), ar,
                        int'(magic), m_fe, m_sc);
    endfunction

    task automatic model_edge();
        int s;
        s = cur_scad();
        if (m_done) begin
            m_done = 1'b0;
        end else if (m_left > 0) begin
            if (abort) begin
                m_left = 0;
            end else begin
                m_sc = (m_sc - 1) & MASK;
                m_left--;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    done_q.push_back(m_span);
                end
            end
        end else if (start) begin
            m_sc = s;
            if (to_s(s) > 0) begin
                m_left = to_s(s);
                m_span = m_left;
            end else begin
                m_done = 1'b1;
                done_q.push_back(0);
            end
        end else if (sc_load) begin
            m_sc = s;
        end
        if (fe_load) m_fe = s;
    endtask

    task automatic push_expect();
        exp_t e;
        int   s;
        bit   bsy;
        s = cur_scad();
        bsy = (m_left > 0);
        e.scad  = s;
        e.fe    = m_fe;
        e.sc    = m_sc;
        e.flags = (int'(s == 0) << 4) | (int'(s >= 512) << 3) | (int'(m_fe >= 512) << 2)
                | (int'(m_sc >= 512) << 1) | int'(to_s(m_sc) >= THRESH);
        e.ctl   = (int'(bsy) << 2) | (int'(bsy && !abort) << 1) | int'(m_done);
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [2:0] op, input logic [1:0] as, input logic [1:0] bs,
                         input logic [35:0] a_r, input logic [8:0] mg,
                         input logic fl, input logic sl, input logic st, input logic ab);
        @(posedge clk);
        model_edge();
        #1;
        scad_op = op; scada_sel = as; scadb_sel = bs; ar = a_r; magic = mg;
        fe_load = fl; sc_load = sl; start = st; abort = ab;
        push_expect();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(3'd0, 2'd0, 2'd0, 36'd0, 9'd0, 0, 0, 0, 0);
    endtask

    task automatic zero_inputs();
        scad_op = 3'd0; scada_sel = 2'd0; scadb_sel = 2'd0; ar = '0; magic = '0;
        fe_load = 0; sc_load = 0; start = 0; abort = 0;
    endtask

    task automatic reset_mid();
        @(posedge clk);
        model_edge();
        #3;
        rst_n = 1'b0;
        zero_inputs();
        #1;
        chk("rst_fe", int'(fe), 0);
        chk("rst_sc", int'(sc), 0);
        chk("rst_ctl", int'({busy, step, done}), 0);
        m_fe = 0; m_sc = 0; m_left = 0; m_done = 1'b0;
        done_q.delete();
        @(posedge clk);
        #1;
        chk("rst_hold_sc", int'(sc), 0);
        rst_n = 1'b1;
    endtask

    // Monitor: every unreset cycle presents outputs that are checked against the queue.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("scad", int'(scad), e.scad);
            chk("fe", int'(fe), e.fe);
            chk("sc", int'(sc), e.sc);
            chk("flags", int'({scad_eq0, scad_sign, fe_sign, sc_sign, sc_ge_thresh}), e.flags);
            chk("busy_step_done", int'({busy, step, done}), e.ctl);
            if (done) begin
                if (done_q.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    chk("loop_steps", steps_seen, done_q.pop_front());
                end
                steps_seen = 0;
            end else if (!busy) begin
                steps_seen = 0;
            end
            if (step) steps_seen++;
        end
    end

    initial begin
        logic [63:0] rnd;
        zero_inputs();
        #3;
        chk("por_fe", int'(fe), 0);
        chk("por_sc", int'(sc), 0);
        chk("por_ctl", int'({busy, step, done}), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Negative count from magic: zero steps, immediate done.
        drive(3'd0, 2'd3, 2'd3, 36'd0, 9'h1F0, 0, 0, 1, 0);
        idle(3);
        // FE=5 then count from FE: five steps.
        drive(3'd0, 2'd1, 2'd0, 36'd5, 9'd0, 1, 0, 0, 0);
        drive(3'd0, 2'd0, 2'd0, 36'd0, 9'd0, 0, 0, 1, 0);
        idle(8);
        // Count 8, abort on the third step cycle.
        drive(3'd0, 2'd1, 2'd0, 36'd8, 9'd0, 0, 0, 1, 0);
        idle(2);
        drive(3'd0, 2'd0, 2'd0, 36'd0, 9'd0, 0, 0, 0, 1);
        idle(2);
        // FE = 0x0FF - (-256) = 0x1FF, then 0x1FF + 1 and 0 - 1 wraps.
        drive(3'd5, 2'd3, 2'd1, 36'h100 << 27, 9'h0FF, 1, 0, 0, 0);
        drive(3'd2, 2'd0, 2'd1, 36'h001 << 27, 9'd0, 0, 0, 0, 0);
        drive(3'd3, 2'd1, 2'd3, 36'd0, 9'd0, 0, 0, 0, 0);
        // Threshold boundaries through sc_load.
        drive(3'd0, 2'd1, 2'd0, 36'd36, 9'd0, 0, 1, 0, 0);
        drive(3'd0, 2'd1, 2'd0, 36'd35, 9'd0, 0, 1, 0, 0);
        drive(3'd0, 2'd3, 2'd0, 36'd0, 9'h1FF, 0, 1, 0, 0);
        drive(3'd0, 2'd1, 2'd0, 36'd0, 9'd0, 0, 0, 0, 0);
        // Start and sc_load together: start wins.
        drive(3'd0, 2'd1, 2'd0, 36'd3, 9'd0, 0, 1, 1, 0);
        idle(6);
        // Reset in the middle of a loop once SC has reached 5.
        drive(3'd0, 2'd1, 2'd0, 36'd7, 9'd0, 0, 0, 1, 0);
        idle(2);
        reset_mid();
        idle(3);

        for (int i = 0; i < 3000; i++) begin
            rnd = {$urandom(), $urandom()};
            drive(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), rnd[35:0], 9'($urandom_range(0, 511)),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 31) == 0));
        end
        for (int i = 0; i < 600 && (m_left > 0 || m_done); i++) idle(1);
        idle(2);
        @(negedge clk);
        #1;
        chk("exp_q_drained", exp_q.size(), 0);
        chk("done_q_drained", done_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/scad_seq.md
SCAD_SEQ -- requirements
Module: scad_seq

Interface
REQ-001 Parameter W, default 10: width of FE, SC and the SCAD adder, in bits.
REQ-002 Parameter AR_W, default 36: width of the AR input; AR bit 0 is the MSB.
REQ-003 Parameter MAGIC_W, default 9: width of the CRAM magic field.
REQ-004 Parameter THRESH, default 36: signed compare threshold for sc_ge_thresh.
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 scad_op  input  3  SCAD function select.
REQ-008 scada_sel  input  2  SCADA source select.
REQ-009 scadb_sel  input  2  SCADB source select.
REQ-010 ar  input  AR_W  AR register contents, bits [0:AR_W-1].
REQ-011 magic  input  MAGIC_W  CRAM magic number.
REQ-012 fe_load  input  1  latch scad into FE.
REQ-013 sc_load  input  1  latch scad into SC; valid in IDLE only.
REQ-014 start  input  1  begin a shift-count loop using scad as the count.
REQ-015 abort  input  1  terminate an active loop.
REQ-016 scad  output  W  combinational adder result.
REQ-017 fe  output  W  FE register.
REQ-018 sc  output  W  SC register.
REQ-019 scad_eq0, scad_sign, fe_sign, sc_sign, sc_ge_thresh  output  1 each  status flags.
REQ-020 busy  output  1  high while in COUNT.
REQ-021 step  output  1  one shift-step strobe per counted cycle.
REQ-022 done  output  1  one-cycle pulse marking loop completion.

Function
REQ-023 SCADA SHALL be selected as: 0 = FE; 1 = ar[AR_W-6:AR_W-1] zero-extended; 2 = ar[0:8] sign-extended from ar[0]; 3 = magic sign-extended.
REQ-024 SCADB SHALL be selected as: 0 = SC; 1 = ar[0:8] sign-extended; 2 = FE; 3 = zero.
REQ-025 scad_op SHALL be decoded as: 0 A; 1 A-B-1; 2 A+B; 3 A-1; 4 A+1; 5 A-B; 6 A|B; 7 A&B.
REQ-026 All arithmetic SHALL be W-bit two's complement, wrapping modulo 2^W, with no saturation.
REQ-027 Flags SHALL be defined as: scad_eq0 = (scad==0); scad_sign = scad MSB; fe_sign = fe MSB; sc_sign = sc MSB; sc_ge_thresh = signed(sc) >= THRESH.
REQ-028 fe_load SHALL set FE<=scad at the next edge, in any state.
REQ-029 The FSM SHALL have exactly three states: IDLE, COUNT, DONE.
REQ-030 IDLE with start: SC<=scad; go to DONE if scad is zero or negative, otherwise go to COUNT.
REQ-031 IDLE with sc_load and no start: SC<=scad, state stays IDLE.
REQ-032 IDLE with start and sc_load together: start takes precedence.
REQ-033 COUNT: step=1 and busy=1; SC<=SC-1 each cycle; when SC==1, go to DONE.
REQ-034 A positive count N SHALL produce exactly N step cycles; a count <=0 SHALL produce zero steps.
REQ-035 COUNT with abort: go to IDLE with no step that cycle and no done pulse; SC holds its value.
REQ-036 abort outside COUNT SHALL be ignored.
REQ-037 DONE: done=1 for one cycle, then unconditionally go to IDLE.
REQ-038 In DONE, start is ignored and no step is produced.
REQ-039 start and sc_load SHALL be ignored in COUNT and DONE.
REQ-040 The flags and scad SHALL always reflect current inputs and register values, in any state.

Reset
REQ-041 With rst_n low, SHALL hold FE=0, SC=0, state=IDLE, busy=0, step=0, done=0, independent of clk.
REQ-042 Reset asserted mid-COUNT SHALL abandon the loop with no done pulse.
REQ-043 After rst_n rises, the first edge SHALL be processed normally.

Structure
REQ-044 Package scad_pkg SHALL hold: the scad_op encodings, the SCADA/SCADB select encodings, and the state enum (IDLE, COUNT, DONE).
REQ-045 One sub-module, scad_alu, SHALL implement the combinational source muxes, the adder and the function decode; scad_seq holds the registers and FSM.

Verification
REQ-046 Reset asserted mid-COUNT with SC=5 -> FE=0, SC=0, busy=0 immediately; no done pulse.
REQ-047 scada_sel=3, magic=0x1F0 (-16), scadb_sel=3, scad_op=0, start -> SC=0x3F0, DONE next cycle, 0 steps, done pulse.
REQ-048 FE=5 via fe_load; scada_sel=0, scad_op=0, start -> exactly 5 step cycles, SC goes 5,4,3,2,1,0, then done for 1 cycle, then IDLE.
REQ-049 start with count 8, abort asserted on the 3rd step cycle -> 2 steps total, SC=6, IDLE, no done.
REQ-050 Op wrap: A=0x1FF, B=0x001, scad_op=2 (A+B) -> scad=0x200, scad_sign=1; A=0, scad_op=3 -> scad=0x3FF.
REQ-051 sc_load with scad=36 -> sc_ge_thresh=1; with scad=35 -> 0; with scad=0x3FF -> 0.
